// File: rtl/dmem_port_scheduler_pkg.sv
// Shared address map, widths and TX FSM encoding for the data-memory port scheduler.
package dmem_port_scheduler_pkg;

  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BUF_LOG    = 4;
  localparam int unsigned STARVE_LIM = 8;

  localparam logic [ADDR_W-1:0] RX0_BASE = 12'h100;
  localparam logic [ADDR_W-1:0] RX1_BASE = 12'h110;
  localparam logic [ADDR_W-1:0] TX0_ADDR = 12'hFF0;
  localparam logic [ADDR_W-1:0] TX1_ADDR = 12'hFF1;
  localparam logic [ADDR_W-1:0] RP0_ADDR = 12'hFF2;
  localparam logic [ADDR_W-1:0] RP1_ADDR = 12'hFF3;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_WAIT  = 2'd1,
    T_PULSE = 2'd2
  } txState_e;

  // UART bytes land in memory as sign-extended words.
  function automatic logic [DATA_W-1:0] sextByte(input logic [BYTE_W-1:0] b);
    return {{(DATA_W-BYTE_W){b[BYTE_W-1]}}, b};
  endfunction

endpackage

// File: rtl/dmem_port_scheduler_if.sv
// MEM-stage request bus between the CPU pipeline and the port scheduler.
interface dmem_port_scheduler_if;
  import dmem_port_scheduler_pkg::*;

  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;

  modport master (output cpu_addr, cpu_rd, cpu_wr, cpu_wdata, input cpu_stall);
  modport slave  (input cpu_addr, cpu_rd, cpu_wr, cpu_wdata, output cpu_stall);
endinterface

// File: rtl/rx_buf_ctrl.sv
// Per-channel RX circular buffer bookkeeping: pointers, full test, overflow and starvation count.
module rx_buf_ctrl
  import dmem_port_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               rxReady,
  input  logic               grant,
  input  logic               rpLoad,
  input  logic [BUF_LOG-1:0] rpVal,
  output logic               req,
  output logic               starve,
  output logic               full,
  output logic               ovf,
  output logic [BUF_LOG-1:0] wptr
);
  localparam int unsigned CNT_W = $clog2(STARVE_LIM + 1);

  logic [BUF_LOG-1:0] rptr;
  logic [CNT_W-1:0]   starveCnt;

  assign req    = rxReady;
  assign starve = rxReady && (starveCnt == CNT_W'(STARVE_LIM));
  assign full   = (wptr + BUF_LOG'(1)) == rptr;

  // A granted byte is always consumed; it is only stored when there is room.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      ovf       <= 1'b0;
      starveCnt <= '0;
    end else begin
      if (grant && !full) wptr <= wptr + BUF_LOG'(1);
      if (rpLoad) rptr <= rpVal;
      if (rpLoad) ovf <= 1'b0;
      else if (grant && full) ovf <= 1'b1;
      if (grant) starveCnt <= '0;
      else if (rxReady && starveCnt != CNT_W'(STARVE_LIM)) starveCnt <= starveCnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_port_scheduler.sv
// Arbitrates the single dataMem port among the CPU MEM stage and two UART RX channels,
// and decodes CPU stores to the UART TX and RX read-pointer registers.
module dmem_port_scheduler
  import dmem_port_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  dmem_port_scheduler_if.slave cpu,
  input  logic                rx0_ready,
  input  logic                rx1_ready,
  input  logic [BYTE_W-1:0]   rx0_data,
  input  logic [BYTE_W-1:0]   rx1_data,
  output logic                rx0_clear,
  output logic                rx1_clear,
  input  logic                tx0_busy,
  input  logic                tx1_busy,
  output logic                tx0_en,
  output logic                tx1_en,
  output logic [BYTE_W-1:0]   tx_data,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_wren,
  output logic                mem_rden,
  output logic [BUF_LOG-1:0]  rx0_wptr,
  output logic [BUF_LOG-1:0]  rx1_wptr,
  output logic                ovf0,
  output logic                ovf1
);
  txState_e state;
  logic     txCh, rrFav;
  logic     cpuRd, cpuWr, rdy0, rdy1;
  logic     isTx0, isTx1, isRp0, isRp1, cpuMem, txStore, txAccept;
  logic     req0, req1, starve0, starve1, full0, full1, starveAny;
  logic     grant0, grant1, txBusyTgt, txBusyNew;

  // Holding reset forces every combinational output low regardless of inputs.
  assign cpuRd = cpu.cpu_rd & rst;
  assign cpuWr = cpu.cpu_wr & rst;
  assign rdy0  = rx0_ready & rst;
  assign rdy1  = rx1_ready & rst;

  assign isTx0     = cpu.cpu_addr == TX0_ADDR;
  assign isTx1     = cpu.cpu_addr == TX1_ADDR;
  assign isRp0     = cpu.cpu_addr == RP0_ADDR;
  assign isRp1     = cpu.cpu_addr == RP1_ADDR;
  assign cpuMem    = (cpuRd | cpuWr) & ~(isTx0 | isTx1 | isRp0 | isRp1);
  assign txStore   = cpuWr & (isTx0 | isTx1);
  assign starveAny = starve0 | starve1;
  assign txAccept  = (state == T_IDLE) & txStore & ~starveAny;
  assign txBusyTgt = txCh  ? tx1_busy : tx0_busy;
  assign txBusyNew = isTx1 ? tx1_busy : tx0_busy;

  assign cpu.cpu_stall = starveAny
                       | ((state == T_WAIT)  & txBusyTgt)
                       | ((state == T_PULSE) & txStore)
                       | ((state == T_IDLE)  & txStore & txBusyNew);

  rx_buf_ctrl rxBuf0 (
    .clk(clk), .rst(rst), .rxReady(rdy0), .grant(grant0),
    .rpLoad(cpuWr & isRp0 & ~starveAny), .rpVal(cpu.cpu_wdata[BUF_LOG-1:0]),
    .req(req0), .starve(starve0), .full(full0), .ovf(ovf0), .wptr(rx0_wptr)
  );

  rx_buf_ctrl rxBuf1 (
    .clk(clk), .rst(rst), .rxReady(rdy1), .grant(grant1),
    .rpLoad(cpuWr & isRp1 & ~starveAny), .rpVal(cpu.cpu_wdata[BUF_LOG-1:0]),
    .req(req1), .starve(starve1), .full(full1), .ovf(ovf1), .wptr(rx1_wptr)
  );

  // Starving channels pre-empt the CPU; otherwise RX only gets idle memory cycles.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (starveAny) begin
      if (starve0 && starve1) begin
        grant0 = ~rrFav;
        grant1 = rrFav;
      end else begin
        grant0 = starve0;
        grant1 = starve1;
      end
    end else if (!cpuMem) begin
      if (req0 && req1) begin
        grant0 = ~rrFav;
        grant1 = rrFav;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    mem_rden  = 1'b0;
    if (grant0) begin
      mem_addr  = RX0_BASE + ADDR_W'(rx0_wptr);
      mem_wdata = sextByte(rx0_data);
      mem_wren  = ~full0;
    end else if (grant1) begin
      mem_addr  = RX1_BASE + ADDR_W'(rx1_wptr);
      mem_wdata = sextByte(rx1_data);
      mem_wren  = ~full1;
    end else if (cpuMem) begin
      mem_addr  = cpu.cpu_addr;
      mem_wdata = cpu.cpu_wdata;
      mem_wren  = cpuWr;
      mem_rden  = cpuRd;
    end
  end

  assign rx0_clear = grant0;
  assign rx1_clear = grant1;

  // After a contended grant the other channel is favoured next time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rrFav <= 1'b0;
    else if (req0 && req1 && (grant0 || grant1)) rrFav <= grant0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= T_IDLE;
      txCh    <= 1'b0;
      tx_data <= '0;
      tx0_en  <= 1'b0;
      tx1_en  <= 1'b0;
    end else begin
      tx0_en <= 1'b0;
      tx1_en <= 1'b0;
      unique case (state)
        T_IDLE: begin
          if (txAccept) begin
            tx_data <= cpu.cpu_wdata[BYTE_W-1:0];
            txCh    <= isTx1;
            if (txBusyNew) begin
              state <= T_WAIT;
            end else begin
              state  <= T_PULSE;
              tx0_en <= ~isTx1;
              tx1_en <= isTx1;
            end
          end
        end
        T_WAIT: begin
          if (!txBusyTgt) begin
            state  <= T_PULSE;
            tx0_en <= ~txCh;
            tx1_en <= txCh;
          end
        end
        T_PULSE: state <= T_IDLE;
        default: state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_scheduler.sv
// Scoreboard bench for dmem_port_scheduler: per-cycle expected port values are queued at drive time.
module tb_dmem_port_scheduler;
  import dmem_port_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx0_ready, rx1_ready, rx0_clear, rx1_clear;
  logic [7:0]  rx0_data, rx1_data, tx_data;
  logic        tx0_busy, tx1_busy, tx0_en, tx1_en;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wren, mem_rden, ovf0, ovf1;
  logic [3:0]  rx0_wptr, rx1_wptr;

  always #5 clk = ~clk;

  dmem_port_scheduler_if ifc ();

  dmem_port_scheduler dut (
    .clk(clk), .rst(rst), .cpu(ifc),
    .rx0_ready(rx0_ready), .rx1_ready(rx1_ready), .rx0_data(rx0_data), .rx1_data(rx1_data),
    .rx0_clear(rx0_clear), .rx1_clear(rx1_clear), .tx0_busy(tx0_busy), .tx1_busy(tx1_busy),
    .tx0_en(tx0_en), .tx1_en(tx1_en), .tx_data(tx_data), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rden(mem_rden),
    .rx0_wptr(rx0_wptr), .rx1_wptr(rx1_wptr), .ovf0(ovf0), .ovf1(ovf1)
  );

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic wren, rden, stall, c0, c1, t0, t1;
  } exp_t;

  exp_t sbQ[$];
  int   nChecks = 0;
  int   nFails  = 0;
  int   wp0m, wp1m;
  bit   favm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setIn(input logic [11:0] a, input logic rd, input logic wr, input logic [31:0] wd,
                       input logic r0, input logic [7:0] d0, input logic r1, input logic [7:0] d1,
                       input logic b0, input logic b1);
    ifc.cpu_addr = a; ifc.cpu_rd = rd; ifc.cpu_wr = wr; ifc.cpu_wdata = wd;
    rx0_ready = r0; rx0_data = d0; rx1_ready = r1; rx1_data = d1;
    tx0_busy = b0; tx1_busy = b1;
  endtask

  task automatic idle();
    setIn(12'h0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0);
  endtask

  task automatic expOut(input logic [11:0] a, input logic [31:0] wd, input logic wren, input logic rden,
                        input logic stall, input logic c0, input logic c1, input logic t0, input logic t1);
    sbQ.push_back('{a, wd, wren, rden, stall, c0, c1, t0, t1});
  endtask

  // Compare one queued expectation on the falling edge, then advance past the next rising edge.
  task automatic cycle(input string tag);
    exp_t e;
    @(negedge clk);
    if (sbQ.size() == 0) begin
      chk({tag, ".sb_underflow"}, 32'd0, 32'd1);
    end else begin
      e = sbQ.pop_front();
      chk({tag, ".stall"}, ifc.cpu_stall, e.stall);
      chk({tag, ".wren"}, mem_wren, e.wren);
      chk({tag, ".rden"}, mem_rden, e.rden);
      chk({tag, ".clr0"}, rx0_clear, e.c0);
      chk({tag, ".clr1"}, rx1_clear, e.c1);
      chk({tag, ".tx0en"}, tx0_en, e.t0);
      chk({tag, ".tx1en"}, tx1_en, e.t1);
      if (e.wren || e.rden) chk({tag, ".addr"}, mem_addr, e.addr);
      if (e.wren) chk({tag, ".wdata"}, mem_wdata, e.wdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    idle();
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #3;
    chk("rst.stall", ifc.cpu_stall, 0);
    chk("rst.wren", mem_wren, 0);
    chk("rst.tx0en", tx0_en, 0);
    chk("rst.wptr0", rx0_wptr, 0);
    chk("rst.ovf0", ovf0, 0);
    chk("rst.txdata", tx_data, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single RX0 byte into an idle memory port
    setIn(12'h0, 0, 0, 32'h0, 1, 8'h85, 0, 8'h0, 0, 0);
    expOut(12'h100, 32'hFFFFFF85, 1, 0, 0, 1, 0, 0, 0);
    cycle("rx0_first");
    idle();
    chk("rx0_first.wptr", rx0_wptr, 1);

    // Both channels ready: round-robin alternation
    wp0m = 1; wp1m = 0; favm = 1'b0;
    setIn(12'h0, 0, 0, 32'h0, 1, 8'h12, 1, 8'hF0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (!favm) begin
        expOut(12'h100 + 12'(wp0m), 32'h12, 1, 0, 0, 1, 0, 0, 0);
        wp0m++;
      end else begin
        expOut(12'h110 + 12'(wp1m), 32'hFFFFFFF0, 1, 0, 0, 0, 1, 0, 0);
        wp1m++;
      end
      favm = ~favm;
      cycle("rr");
    end
    idle();
    chk("rr.wptr0", rx0_wptr, 4'(wp0m));
    chk("rr.wptr1", rx1_wptr, 4'(wp1m));

    // Fill RX0 to full, overflow, then move rptr via RP0 store
    doReset();
    for (int i = 0; i < 15; i++) begin
      setIn(12'h0, 0, 0, 32'h0, 1, 8'(i), 0, 8'h0, 0, 0);
      expOut(12'h100 + 12'(i), 32'(i), 1, 0, 0, 1, 0, 0, 0);
      cycle("fill");
    end
    setIn(12'h0, 0, 0, 32'h0, 1, 8'hAA, 0, 8'h0, 0, 0);
    expOut(12'h0, 32'h0, 0, 0, 0, 1, 0, 0, 0);
    cycle("full");
    idle();
    chk("full.ovf0", ovf0, 1);
    chk("full.wptr0", rx0_wptr, 15);
    setIn(RP0_ADDR, 0, 1, 32'd5, 0, 8'h0, 0, 8'h0, 0, 0);
    expOut(12'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    cycle("rp0");
    idle();
    chk("rp0.ovf0", ovf0, 0);
    setIn(12'h0, 0, 0, 32'h0, 1, 8'h7F, 0, 8'h0, 0, 0);
    expOut(12'h10F, 32'h7F, 1, 0, 0, 1, 0, 0, 0);
    cycle("after_rp");
    idle();
    chk("after_rp.wptr0", rx0_wptr, 0);

    // CPU store to ordinary memory beats a ready RX channel
    setIn(12'h055, 0, 1, 32'hDEADBEEF, 1, 8'h01, 0, 8'h0, 0, 0);
    expOut(12'h055, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 0);
    cycle("cpu_prio");

    // Starvation guard: CPU loads every cycle with RX1 waiting
    setIn(12'h020, 1, 0, 32'h0, 0, 8'h0, 1, 8'h33, 0, 0);
    for (int i = 0; i < 8; i++) begin
      expOut(12'h020, 32'h0, 0, 1, 0, 0, 0, 0, 0);
      cycle("starve_wait");
    end
    expOut(12'h110, 32'h33, 1, 0, 1, 0, 1, 0, 0);
    cycle("starve_grant");
    expOut(12'h020, 32'h0, 0, 1, 0, 0, 0, 0, 0);
    cycle("replay");
    idle();
    chk("starve.wptr1", rx1_wptr, 1);

    // TX0 store while busy, then back-to-back TX1 store during the pulse
    setIn(TX0_ADDR, 0, 1, 32'h41, 0, 8'h0, 0, 8'h0, 1, 0);
    expOut(12'h0, 32'h0, 0, 0, 1, 0, 0, 0, 0);
    cycle("tx_busy");
    expOut(12'h0, 32'h0, 0, 0, 1, 0, 0, 0, 0);
    cycle("tx_wait1");
    expOut(12'h0, 32'h0, 0, 0, 1, 0, 0, 0, 0);
    cycle("tx_wait2");
    tx0_busy = 1'b0;
    expOut(12'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    cycle("tx_release");
    chk("tx.data0", tx_data, 8'h41);
    setIn(TX1_ADDR, 0, 1, 32'h42, 0, 8'h0, 0, 8'h0, 0, 0);
    expOut(12'h0, 32'h0, 0, 0, 1, 0, 0, 1, 0);
    cycle("tx_pulse0");
    expOut(12'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    cycle("tx1_accept");
    idle();
    chk("tx.data1", tx_data, 8'h42);
    expOut(12'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1);
    cycle("tx_pulse1");
    expOut(12'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    cycle("tx_done");

    // Reset while waiting on a busy transmitter abandons the transmit
    setIn(TX0_ADDR, 0, 1, 32'h55, 0, 8'h0, 0, 8'h0, 1, 0);
    expOut(12'h0, 32'h0, 0, 0, 1, 0, 0, 0, 0);
    cycle("wait_enter");
    expOut(12'h0, 32'h0, 0, 0, 1, 0, 0, 0, 0);
    cycle("wait_hold");
    #1 rst = 1'b0;
    #1;
    chk("mid_rst.stall", ifc.cpu_stall, 0);
    chk("mid_rst.tx0en", tx0_en, 0);
    chk("mid_rst.txdata", tx_data, 0);
    chk("mid_rst.wptr1", rx1_wptr, 0);
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expOut(12'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
      cycle("post_rst");
    end

    chk("sb_empty", 32'(sbQ.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
